// File: rtl/seg_pkg.sv
// Shared definitions for 7-segment display blocks: segment patterns, bit order
// and scan FSM state encoding.
package seg_pkg;

  // Patterns are {a,b,c,d,e,f,g}; the segment bus appends dp below g.
  localparam int SEG_A_BIT  = 7;
  localparam int SEG_G_BIT  = 1;
  localparam int SEG_DP_BIT = 0;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } scan_state_t;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Digit write port of the scan controller.
// Handshake: wr_en is a one-cycle strobe qualifying wr_addr/wr_data/wr_dp;
// every strobe is accepted on the same rising edge, there is no ready.
interface seg_scan_ctrl_if;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic       wr_dp;

  modport master (output wr_en, output wr_addr, output wr_data, output wr_dp);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data, input  wr_dp);
endinterface

// File: rtl/seg_decoder.sv
// BCD to 7-segment pattern {a..g}; codes 10-15 give a blank digit.
module seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] pattern
);

  always_comb begin
    case (bcd)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-cathode 7-segment display:
// digit register file, IDLE/SHOW/BLANK scan FSM and registered seg/com drive.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 10000,
  parameter int BLANK_CYC  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  lz_suppress,
  seg_scan_ctrl_if.slave        wr,
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] com,
  output logic [2:0]            scan_idx,
  output scan_state_t           dbg_state
);

  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [2:0]       LAST_IDX   = 3'(NUM_DIGITS - 1);
  localparam logic [3:0]       NUM_DIG4   = 4'(NUM_DIGITS);

  scan_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic             en_q;

  // Full 8-entry file; entries at or above NUM_DIGITS are never written and stay 0.
  logic [3:0]       digit_q [8];
  logic [7:0]       dp_q;

  logic [6:0]            pattern;
  logic [3:0]            cur_digit;
  logic                  upper_zero;
  logic                  lz_blank;
  logic [7:0]            seg_d;
  logic [NUM_DIGITS-1:0] com_d;

  // State register; en_q delays scan start by one edge after enable rises.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      en_q    <= enable;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          idx_d = '0;
          if (en_q) state_d = SHOW;
        end
        SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            cnt_d   = '0;
            state_d = BLANK;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            cnt_d   = '0;
            state_d = SHOW;
            idx_d   = (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) digit_q[i] <= 4'd0;
      dp_q <= '0;
    end else if (wr.wr_en && ({1'b0, wr.wr_addr} < NUM_DIG4)) begin
      digit_q[wr.wr_addr] <= wr.wr_data;
      dp_q[wr.wr_addr]    <= wr.wr_dp;
    end
  end

  assign cur_digit = digit_q[idx_q];

  seg_decoder u_decoder (
    .bcd     (cur_digit),
    .pattern (pattern)
  );

  // A zero is leading only if every more significant digit is also zero.
  always_comb begin
    upper_zero = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if ((3'(i) > idx_q) && (digit_q[i] != 4'd0)) upper_zero = 1'b0;
    end
  end

  assign lz_blank = lz_suppress && (idx_q != 3'd0) && (cur_digit == 4'd0) && upper_zero;

  always_comb begin
    seg_d = 8'h00;
    com_d = '1;
    if (state_q == SHOW) begin
      com_d = ~(NUM_DIGITS'(1) << idx_q);
      seg_d = {(lz_blank ? SEG_BLANK : pattern), dp_q[idx_q]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      seg <= 8'h00;
      com <= '1;
    end else begin
      seg <= seg_d;
      com <= com_d;
    end
  end

  assign scan_idx  = idx_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with 4 digits, 4 lit cycles, 2 blank cycles.
module tb_seg_scan_ctrl;
  import seg_pkg::*;

  localparam int ND    = 4;
  localparam int FRAME = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          lz_suppress;
  logic [7:0]    seg;
  logic [ND-1:0] com;
  logic [2:0]    scan_idx;
  scan_state_t   dbg_state;

  seg_scan_ctrl_if wr_bus ();

  seg_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(4), .BLANK_CYC(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .lz_suppress (lz_suppress),
    .wr          (wr_bus.slave),
    .seg         (seg),
    .com         (com),
    .scan_idx    (scan_idx),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_seg [ND];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_digit(input logic [2:0] addr, input logic [3:0] data, input logic dp);
    wr_bus.wr_en   = 1'b1;
    wr_bus.wr_addr = addr;
    wr_bus.wr_data = data;
    wr_bus.wr_dp   = dp;
    tick();
    wr_bus.wr_en = 1'b0;
  endtask

  task automatic check_dark(input string tag);
    check_eq({tag, "_seg"}, 32'(seg), 32'h00);
    check_eq({tag, "_com"}, 32'(com), 32'hF);
  endtask

  // Raise enable: one edge to sample it, one edge to enter SHOW.
  task automatic start_scan();
    enable = 1'b1;
    tick();
    check_eq("start_idle", 32'(dbg_state), 32'(IDLE));
    tick();
    check_eq("start_show", 32'(dbg_state), 32'(SHOW));
    check_eq("start_com", 32'(com), 32'hF);
    check_eq("start_idx", 32'(scan_idx), 32'd0);
  endtask

  // Check n cycles of scan; p = 0 is the first edge with digit 0 lit.
  // Optionally write a digit before edge p == wr_p; it shows from p == wr_p + 1.
  task automatic run_scan(input int n, input int wr_p, input logic [2:0] wa,
                          input logic [3:0] wd, input logic wdp, input logic [7:0] wseg);
    int ph, dg, nxt;
    logic lit;
    logic [ND-1:0] e_com;
    logic [7:0] e_seg;
    for (int p = 0; p < n; p++) begin
      if (p == wr_p) begin
        wr_bus.wr_en   = 1'b1;
        wr_bus.wr_addr = wa;
        wr_bus.wr_data = wd;
        wr_bus.wr_dp   = wdp;
      end else begin
        wr_bus.wr_en = 1'b0;
      end
      tick();
      ph    = p % FRAME;
      dg    = ph / 6;
      lit   = (ph % 6) < 4;
      e_com = lit ? ~(ND'(1) << dg) : '1;
      e_seg = lit ? exp_seg[dg] : 8'h00;
      nxt   = ((p + 1) % FRAME) / 6;
      check_eq($sformatf("com_p%0d", p), 32'(com), 32'(e_com));
      check_eq($sformatf("seg_p%0d", p), 32'(seg), 32'(e_seg));
      check_eq($sformatf("idx_p%0d", p), 32'(scan_idx), 32'(nxt));
      if (p == wr_p) exp_seg[wa[1:0]] = wseg;
    end
    wr_bus.wr_en = 1'b0;
  endtask

  task automatic stop_scan();
    enable = 1'b0;
    tick();
    tick();
    check_dark("stop");
  endtask

  initial begin
    rst            = 1'b0;
    enable         = 1'b0;
    lz_suppress    = 1'b0;
    wr_bus.wr_en   = 1'b0;
    wr_bus.wr_addr = 3'd0;
    wr_bus.wr_data = 4'd0;
    wr_bus.wr_dp   = 1'b0;
    tick();
    tick();
    check_dark("reset");
    check_eq("reset_idx", 32'(scan_idx), 32'd0);
    check_eq("reset_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b1;

    for (int i = 0; i < 20; i++) begin
      tick();
      check_dark($sformatf("idle%0d", i));
      check_eq($sformatf("idle%0d_idx", i), 32'(scan_idx), 32'd0);
    end

    // Digits 1,2,3,4: two full frames.
    write_digit(3'd0, 4'd1, 1'b0);
    write_digit(3'd1, 4'd2, 1'b0);
    write_digit(3'd2, 4'd3, 1'b0);
    write_digit(3'd3, 4'd4, 1'b0);
    exp_seg[0] = 8'h60;
    exp_seg[1] = 8'hDA;
    exp_seg[2] = 8'hF2;
    exp_seg[3] = 8'h66;
    start_scan();
    run_scan(2 * FRAME, -1, 3'd0, 4'd0, 1'b0, 8'h00);
    stop_scan();

    // Digits {0,0,5,0} with leading-zero suppression.
    write_digit(3'd3, 4'd0, 1'b0);
    write_digit(3'd2, 4'd5, 1'b0);
    write_digit(3'd1, 4'd0, 1'b0);
    write_digit(3'd0, 4'd0, 1'b0);
    lz_suppress = 1'b1;
    exp_seg[0] = 8'hFC;
    exp_seg[1] = 8'hFC;
    exp_seg[2] = 8'hB6;
    exp_seg[3] = 8'h00;
    start_scan();
    run_scan(FRAME, -1, 3'd0, 4'd0, 1'b0, 8'h00);
    stop_scan();

    // Suppression off; write 9 with dp into digit 2 while it is lit.
    lz_suppress = 1'b0;
    exp_seg[3]  = 8'hFC;
    start_scan();
    run_scan(FRAME, 13, 3'd2, 4'd9, 1'b1, 8'hF7);
    stop_scan();

    // Out-of-range addresses are ignored; code 12 blanks digit 1.
    write_digit(3'd1, 4'd12, 1'b0);
    write_digit(3'd5, 4'd8, 1'b1);
    write_digit(3'd4, 4'd7, 1'b1);
    exp_seg[1] = 8'h00;
    start_scan();
    run_scan(FRAME, -1, 3'd0, 4'd0, 1'b0, 8'h00);
    stop_scan();

    // Drop enable while digit 2 is lit.
    start_scan();
    run_scan(14, -1, 3'd0, 4'd0, 1'b0, 8'h00);
    enable = 1'b0;
    tick();
    check_eq("drop_state", 32'(dbg_state), 32'(IDLE));
    check_eq("drop_idx", 32'(scan_idx), 32'd0);
    check_eq("drop_com_hold", 32'(com), 32'hB);
    tick();
    check_dark("drop");

    // Reset pulse mid-scan clears the digits and restarts at digit 0.
    start_scan();
    run_scan(10, -1, 3'd0, 4'd0, 1'b0, 8'h00);
    rst = 1'b0;
    tick();
    check_dark("rst_mid");
    check_eq("rst_mid_idx", 32'(scan_idx), 32'd0);
    check_eq("rst_mid_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b1;
    for (int i = 0; i < ND; i++) exp_seg[i] = 8'hFC;
    start_scan();
    run_scan(FRAME, -1, 3'd0, 4'd0, 1'b0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
